// File: rtl/issue_decode_buffer.sv
// N-wide decode/issue stage: holds one fetch bundle, decodes every slot and releases it as
// hazard-free issue groups on a registered valid/ready output. Optional perf counters: ISSUE_DECODE_PERF_EN.
module issue_decode_buffer #(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned CTRL_W      = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ISSUE_WIDTH-1:0]         in_slot_valid,
  input  logic [ISSUE_WIDTH*INSTR_W-1:0] in_instr,
  output logic [ISSUE_WIDTH-1:0]         out_valid,
  input  logic                           out_ready,
  output logic [ISSUE_WIDTH*INSTR_W-1:0] out_instr,
  output logic [ISSUE_WIDTH*CTRL_W-1:0]  out_ctrl,
  output logic [ISSUE_WIDTH-1:0]         out_illegal
`ifdef ISSUE_DECODE_PERF_EN
  ,
  output logic [31:0]                    cnt_groups,
  output logic [31:0]                    cnt_splits
`endif
);

  function automatic logic [CTRL_W-1:0] decode(input logic [INSTR_W-1:0] ins);
    logic [14:0] c;
    c = '0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20:   c = 15'h0810;
          6'h22:   c = 15'h0811;
          6'h24:   c = 15'h0812;
          default: c = '0;
        endcase
      end
      6'h08:   c = 15'h0C00;
      6'h0D:   c = 15'h0C03;
      6'h23:   c = 15'h2C40;
      6'h2B:   c = 15'h1400;
      6'h04:   c = 15'h4001;
      6'h05:   c = 15'h4041;
      6'h02:   c = 15'h0100;
      6'h03:   c = 15'h0988;
      default: c = '0;
    endcase
    return CTRL_W'(c);
  endfunction

  logic [ISSUE_WIDTH*INSTR_W-1:0] h_instr_q, h_instr_d;
  logic [ISSUE_WIDTH-1:0]         pend_q, pend_d;
  logic [ISSUE_WIDTH-1:0]         out_valid_q, out_valid_d;
  logic [ISSUE_WIDTH*INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ISSUE_WIDTH*CTRL_W-1:0]  out_ctrl_q, out_ctrl_d;
  logic [ISSUE_WIDTH-1:0]         out_illegal_q, out_illegal_d;

  logic [CTRL_W-1:0] ctrl  [ISSUE_WIDTH];
  logic [4:0]        dest  [ISSUE_WIDTH];
  logic [4:0]        rs    [ISSUE_WIDTH];
  logic [4:0]        rt    [ISSUE_WIDTH];
  logic              wr    [ISSUE_WIDTH];
  logic              rd_rs [ISSUE_WIDTH];
  logic              rd_rt [ISSUE_WIDTH];
  logic              mem   [ISSUE_WIDTH];
  logic              ctl   [ISSUE_WIDTH];
  logic              jmp   [ISSUE_WIDTH];
  logic [5:0]        op    [ISSUE_WIDTH];

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
    logic [INSTR_W-1:0] ins;
    assign ins      = h_instr_q[g*INSTR_W +: INSTR_W];
    assign ctrl[g]  = decode(ins);
    assign op[g]    = ins[31:26];
    // J-format words carry PcSrc rather than the Jump bit, so jumps are recognised by opcode.
    assign jmp[g]   = (op[g] == 6'h02) || (op[g] == 6'h03);
    assign rs[g]    = ins[25:21];
    assign rt[g]    = ins[20:16];
    assign wr[g]    = ctrl[g][11];
    assign dest[g]  = (ctrl[g][5:4] == 2'b01) ? ins[15:11] :
                      (ctrl[g][5:4] == 2'b10) ? 5'd31 : ins[20:16];
    assign rd_rs[g] = !jmp[g];
    assign rd_rt[g] = (op[g] == 6'h00) || (op[g] == 6'h2B) || (op[g] == 6'h04) ||
                      (op[g] == 6'h05);
    assign mem[g]   = ctrl[g][13] | ctrl[g][12];
    assign ctl[g]   = ctrl[g][14] | jmp[g];
  end

  // Longest in-order prefix of pending slots free of conflicts with earlier group members.
  logic [ISSUE_WIDTH-1:0] grp;
  logic                   stop, hit;

  always_comb begin
    grp  = '0;
    stop = 1'b0;
    hit  = 1'b0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (pend_q[j] && !stop) begin
        hit = 1'b0;
        for (int i = 0; i < j; i++) begin
          if (grp[i] && (ctl[i] || (mem[i] && mem[j]) ||
              (wr[i] && (dest[i] != 5'd0) &&
               ((wr[j] && (dest[j] == dest[i])) ||
                (rd_rs[j] && (rs[j] == dest[i])) ||
                (rd_rt[j] && (rt[j] == dest[i])))))) begin
            hit = 1'b1;
          end
        end
        if (hit) stop = 1'b1;
        else     grp[j] = 1'b1;
      end
    end
  end

  logic advance;
  assign advance  = (out_valid_q == '0) || out_ready;
  assign in_ready = rst && !flush && ((pend_q == '0) || (advance && (grp == pend_q)));

  always_comb begin
    h_instr_d     = h_instr_q;
    pend_d        = pend_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_ctrl_d    = out_ctrl_q;
    out_illegal_d = out_illegal_q;
    if (!rst || flush) begin
      if (!rst) h_instr_d = '0;
      pend_d        = '0;
      out_valid_d   = '0;
      out_instr_d   = '0;
      out_ctrl_d    = '0;
      out_illegal_d = '0;
    end else begin
      if (advance) begin
        out_valid_d = grp;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
          out_instr_d[s*INSTR_W +: INSTR_W] = grp[s] ? h_instr_q[s*INSTR_W +: INSTR_W] : '0;
          out_ctrl_d[s*CTRL_W +: CTRL_W]    = grp[s] ? ctrl[s] : '0;
          out_illegal_d[s]                  = grp[s] && (ctrl[s] == '0);
        end
        pend_d = pend_q & ~grp;
      end
      if (in_valid && in_ready) begin
        h_instr_d = in_instr;
        pend_d    = in_slot_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    h_instr_q     <= h_instr_d;
    pend_q        <= pend_d;
    out_valid_q   <= out_valid_d;
    out_instr_q   <= out_instr_d;
    out_ctrl_q    <= out_ctrl_d;
    out_illegal_q <= out_illegal_d;
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_illegal = out_illegal_q;

`ifdef ISSUE_DECODE_PERF_EN
  logic [31:0] cnt_groups_q, cnt_groups_d, cnt_splits_q, cnt_splits_d;

  always_comb begin
    cnt_groups_d = cnt_groups_q;
    cnt_splits_d = cnt_splits_q;
    if (!rst) begin
      cnt_groups_d = '0;
      cnt_splits_d = '0;
    end else begin
      if ((out_valid_q != '0) && out_ready) cnt_groups_d = cnt_groups_q + 32'd1;
      if (!flush && advance && (pend_q != '0) && ((pend_q & ~grp) != '0)) begin
        cnt_splits_d = cnt_splits_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    cnt_groups_q <= cnt_groups_d;
    cnt_splits_q <= cnt_splits_d;
  end

  assign cnt_groups = cnt_groups_q;
  assign cnt_splits = cnt_splits_q;
`endif

endmodule

// File: tb/tb_issue_decode_buffer.sv
// Directed bench for issue_decode_buffer (ISSUE_WIDTH=2): vector table of two-slot bundles
// plus hand sequences for backpressure, flush, reset and back-to-back bundles.
module tb_issue_decode_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_slot_valid = 2'b00;
  logic [63:0] in_instr = '0;
  logic [1:0]  out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_instr;
  logic [29:0] out_ctrl;
  logic [1:0]  out_illegal;
`ifdef ISSUE_DECODE_PERF_EN
  logic [31:0] cnt_groups, cnt_splits;
`endif

  issue_decode_buffer #(
    .ISSUE_WIDTH(2),
    .INSTR_W    (32),
    .CTRL_W     (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_slot_valid(in_slot_valid),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_ctrl     (out_ctrl),
    .out_illegal  (out_illegal)
`ifdef ISSUE_DECODE_PERF_EN
    ,
    .cnt_groups   (cnt_groups),
    .cnt_splits   (cnt_splits)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] i0, i1;
    logic [1:0]  sv;
    logic [1:0]  v1;
    logic [29:0] c1;
    logic [1:0]  il1;
    logic [1:0]  v2;
    logic [29:0] c2;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [63:0] filt(input logic [1:0] m, input logic [31:0] i0,
                                       input logic [31:0] i1);
    return {(m[1] ? i1 : 32'h0), (m[0] ? i0 : 32'h0)};
  endfunction

  task automatic send(input logic [1:0] sv, input logic [31:0] i0, input logic [31:0] i1);
    @(posedge clk); #1;
    in_valid      = 1'b1;
    in_slot_valid = sv;
    in_instr      = {i1, i0};
  endtask

  task automatic run_vec(input int k, input vec_t v);
`ifdef ISSUE_DECODE_PERF_EN
    logic [31:0] g0, s0;
    g0 = cnt_groups;
    s0 = cnt_splits;
`endif
    send(v.sv, v.i0, v.i1);
    @(negedge clk);
    check($sformatf("v%0d_accept_ready", k), 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_t1_ready", k), 64'(in_ready), 64'(v.v2 == 2'b00));
    @(posedge clk); @(negedge clk);
    check($sformatf("v%0d_g1_valid", k), 64'(out_valid), 64'(v.v1));
    check($sformatf("v%0d_g1_ctrl", k), 64'(out_ctrl), 64'(v.c1));
    check($sformatf("v%0d_g1_illegal", k), 64'(out_illegal), 64'(v.il1));
    check($sformatf("v%0d_g1_instr", k), out_instr, filt(v.v1, v.i0, v.i1));
    @(posedge clk); @(negedge clk);
    check($sformatf("v%0d_g2_valid", k), 64'(out_valid), 64'(v.v2));
    check($sformatf("v%0d_g2_ctrl", k), 64'(out_ctrl), 64'(v.c2));
    check($sformatf("v%0d_g2_illegal", k), 64'(out_illegal), 64'(2'b00));
    check($sformatf("v%0d_g2_instr", k), out_instr, filt(v.v2, v.i0, v.i1));
    @(posedge clk); @(negedge clk);
    check($sformatf("v%0d_drained", k), 64'(out_valid), 64'(2'b00));
`ifdef ISSUE_DECODE_PERF_EN
    check($sformatf("v%0d_cnt_groups", k), 64'(cnt_groups - g0),
          64'(32'(v.v1 != 2'b00) + 32'(v.v2 != 2'b00)));
    check($sformatf("v%0d_cnt_splits", k), 64'(cnt_splits - s0), 64'(v.v2 != 2'b00));
`endif
  endtask

  initial begin
    logic [31:0] a0, a1;

    vecs[0]  = '{rtype(1, 2, 3, 6'h20), itype(6'h08, 4, 5, 7), 2'b11,
                 2'b11, {15'h0C00, 15'h0810}, 2'b00, 2'b00, 30'h0};
    vecs[1]  = '{itype(6'h08, 0, 1, 5), rtype(1, 2, 3, 6'h20), 2'b11,
                 2'b01, {15'h0, 15'h0C00}, 2'b00, 2'b10, {15'h0810, 15'h0}};
    vecs[2]  = '{itype(6'h23, 1, 2, 0), itype(6'h2B, 1, 4, 4), 2'b11,
                 2'b01, {15'h0, 15'h2C40}, 2'b00, 2'b10, {15'h1400, 15'h0}};
    vecs[3]  = '{itype(6'h04, 1, 2, 3), rtype(0, 0, 0, 6'h20), 2'b11,
                 2'b01, {15'h0, 15'h4001}, 2'b00, 2'b10, {15'h0810, 15'h0}};
    vecs[4]  = '{itype(6'h3F, 0, 0, 0), itype(6'h0D, 7, 6, 1), 2'b11,
                 2'b11, {15'h0C03, 15'h0}, 2'b01, 2'b00, 30'h0};
    vecs[5]  = '{itype(6'h05, 1, 2, 8), rtype(5, 6, 7, 6'h24), 2'b11,
                 2'b01, {15'h0, 15'h4041}, 2'b00, 2'b10, {15'h0812, 15'h0}};
    vecs[6]  = '{itype(6'h08, 1, 4, 1), itype(6'h23, 2, 4, 0), 2'b11,
                 2'b01, {15'h0, 15'h0C00}, 2'b00, 2'b10, {15'h2C40, 15'h0}};
    vecs[7]  = '{jtype(6'h03, 26'h40), rtype(1, 2, 3, 6'h22), 2'b11,
                 2'b01, {15'h0, 15'h0988}, 2'b00, 2'b10, {15'h0811, 15'h0}};
    // j target bits alias rs=$1, but a jump reads no register
    vecs[8]  = '{itype(6'h08, 0, 1, 1), jtype(6'h02, {5'd1, 21'd0}), 2'b11,
                 2'b11, {15'h0100, 15'h0C00}, 2'b00, 2'b00, 30'h0};
    vecs[9]  = '{itype(6'h08, 0, 4, 1), itype(6'h2B, 1, 4, 0), 2'b11,
                 2'b01, {15'h0, 15'h0C00}, 2'b00, 2'b10, {15'h1400, 15'h0}};
    vecs[10] = '{rtype(1, 2, 3, 6'h20), rtype(5, 6, 7, 6'h24), 2'b10,
                 2'b10, {15'h0812, 15'h0}, 2'b00, 2'b00, 30'h0};
    vecs[11] = '{rtype(1, 2, 3, 6'h20), rtype(5, 6, 7, 6'h24), 2'b00,
                 2'b00, 30'h0, 2'b00, 2'b00, 30'h0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(2'b00));
    check("rst_out_ctrl", 64'(out_ctrl), 64'(30'h0));
    check("rst_out_instr", out_instr, 64'h0);
    check("rst_out_illegal", 64'(out_illegal), 64'(2'b00));
    check("rst_in_ready", 64'(in_ready), 64'(1'b0));
    @(posedge clk); #1;
    rst = 1'b1;

    for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);

    // Backpressure across a RAW split
    a0 = itype(6'h08, 0, 1, 5);
    a1 = rtype(1, 2, 3, 6'h20);
    out_ready = 1'b0;
    send(2'b11, a0, a1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), 64'(out_valid), 64'(2'b01));
      check($sformatf("bp%0d_ctrl", c), 64'(out_ctrl), 64'({15'h0, 15'h0C00}));
      check($sformatf("bp%0d_instr", c), out_instr, {32'h0, a0});
      check($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'(1'b0));
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_release_valid", 64'(out_valid), 64'(2'b10));
    check("bp_release_ctrl", 64'(out_ctrl), 64'({15'h0810, 15'h0}));
    @(posedge clk); @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'(2'b00));

    // Flush while slot 1 is still pending; the bundle offered in the flush cycle is dropped
    send(2'b11, a0, a1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    in_valid = 1'b1;
    in_slot_valid = 2'b11;
    in_instr = {vecs[0].i1, vecs[0].i0};
    @(negedge clk);
    check("fl_group1_valid", 64'(out_valid), 64'(2'b01));
    check("fl_in_ready", 64'(in_ready), 64'(1'b0));
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_next_valid", 64'(out_valid), 64'(2'b00));
    @(posedge clk); @(negedge clk);
    check("fl_after_valid", 64'(out_valid), 64'(2'b00));
    check("fl_after_ready", 64'(in_ready), 64'(1'b1));

    // Reset mid-split
    send(2'b11, a0, a1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_in_ready", 64'(in_ready), 64'(1'b0));
    check("mr_group1_valid", 64'(out_valid), 64'(2'b01));
    @(posedge clk); @(negedge clk);
    check("mr_out_valid", 64'(out_valid), 64'(2'b00));
    check("mr_out_ctrl", 64'(out_ctrl), 64'(30'h0));
    check("mr_out_instr", out_instr, 64'h0);
    check("mr_out_illegal", 64'(out_illegal), 64'(2'b00));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mr_discard_valid", 64'(out_valid), 64'(2'b00));
    check("mr_ready_again", 64'(in_ready), 64'(1'b1));

    // Back-to-back non-splitting bundles
    send(2'b11, vecs[0].i0, vecs[0].i1);
    @(negedge clk);
    check("bb_ready0", 64'(in_ready), 64'(1'b1));
    send(2'b11, rtype(1, 2, 3, 6'h22), itype(6'h0D, 7, 6, 1));
    @(negedge clk);
    check("bb_ready1", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bb_g0_valid", 64'(out_valid), 64'(2'b11));
    check("bb_g0_ctrl", 64'(out_ctrl), 64'({15'h0C00, 15'h0810}));
    @(posedge clk); @(negedge clk);
    check("bb_g1_valid", 64'(out_valid), 64'(2'b11));
    check("bb_g1_ctrl", 64'(out_ctrl), 64'({15'h0C03, 15'h0811}));
    @(posedge clk); @(negedge clk);
    check("bb_drained", 64'(out_valid), 64'(2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
